dac_update_scheduler: RTL and testbench
=======================================

DAC_UPDATE_SCHEDULER -- requirements
Module: dac_update_scheduler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, giving clk cycles per SCLK half-period; legal range 2..255.
REQ-002 SHALL have parameter CMD_WRITE, default 4'h3, giving the frame command nibble "write and update DAC channel".
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 dds_gain_update, cw_gain_update, dds_current_limit_update, cw_current_limit_update  input  1 each  one-cycle request strobes from the register file (channels 0..3 in that order).
REQ-006 dds_gain, cw_gain, dds_current_limit, cw_current_limit  input  16 each  channel values, held stable by the register file.
REQ-007 dac_sclk  output  1  SPI clock, idle low (mode 0).
REQ-008 dac_cs_n  output  1  SPI chip select, active low.
REQ-009 dac_mosi  output  1  SPI data, MSB first.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 pending  output  4  per-channel outstanding-request flags.
REQ-012 done  output  4  one-cycle pulse on the bit of the channel whose frame just completed.

Function
REQ-013 Each update strobe SHALL set its pending bit on the following clk edge.
REQ-014 In IDLE with any pending bit set, the block SHALL grant one channel round-robin, starting the search at (last_granted+1) mod 4; after reset last_granted = 3, so channel 0 has first priority.
REQ-015 On the grant cycle the block SHALL capture the channel's current 16-bit value, clear its pending bit, record last_granted, and enter SETUP.
REQ-016 A strobe on a channel's own grant cycle SHALL leave its pending bit set, forcing one further frame carrying the newer value.
REQ-017 Repeated strobes while a bit is already pending SHALL coalesce into one frame, which sends the value present at grant time.
REQ-018 Frame word SHALL be 24 bits: {CMD_WRITE[3:0], 2'b00, ch[1:0], value[15:0]}, shifted MSB first.
REQ-019 SETUP: dac_cs_n low, dac_sclk low, mosi = bit 23, for CLK_DIV cycles; then SHIFT.
REQ-020 SHIFT: 24 SCLK periods; dac_sclk high CLK_DIV cycles, then low CLK_DIV cycles; mosi SHALL change only on the falling edge of dac_sclk (next bit); then HOLD.
REQ-021 HOLD: dac_cs_n low, sclk low, for CLK_DIV cycles; then GAP with dac_cs_n high.
REQ-022 GAP: dac_cs_n high for CLK_DIV cycles; in the last GAP cycle done[ch] SHALL pulse for one cycle; next state IDLE.
REQ-023 Total frame length from the grant cycle to the IDLE return SHALL be 1 + 51*CLK_DIV cycles.
REQ-024 Strobes SHALL be accepted in every state, including mid-frame; they never abort or alter the frame in flight.
REQ-025 dac_mosi SHALL be driven 0 whenever dac_cs_n is high.
REQ-026 Outputs SHALL be registered, with no combinational path from inputs to the dac_* outputs.

Reset
REQ-027 Asserting rst in any cycle, including mid-frame, SHALL on the next edge force: state IDLE, dac_cs_n 1, dac_sclk 0, dac_mosi 0, busy 0, pending 0, done 0, last_granted 3, and clear all counters and the shift register.
REQ-028 Strobes coincident with rst asserted SHALL be discarded.

Structure
REQ-029 A shared package SHALL hold the state enumeration (IDLE, SETUP, SHIFT, HOLD, GAP), the channel index constants (DDS_GAIN=0, CW_GAIN=1, DDS_ILIM=2, CW_ILIM=3), and the frame width constant 24.
REQ-030 The SPI serializer (SETUP..GAP timing, shift register, bit counter) SHALL be one sub-module, dac_spi_frame_tx, with a start/data/done handshake; arbitration and pending logic stay in the top module.

Verification
REQ-031 CLK_DIV=4; after reset, pulse dds_gain_update with dds_gain=16'hA5C3 -> one frame, 24'h30A5C3 decoded on SCLK rising edges, done=4'b0001, total length 205 cycles.
REQ-032 Strobe all four channels in the same cycle -> frames in order ch0,1,2,3, each with its own address, pending drained to 0, no cs_n overlap, GAP of at least 4 cycles between frames.
REQ-033 During the ch1 frame, strobe cw_gain_update three times while changing cw_gain to 1, 2, 3 -> exactly one extra ch1 frame carrying 16'h0003.
REQ-034 Strobe ch2 exactly on its grant cycle -> two ch2 frames back to back.
REQ-035 Assert rst at bit 10 of SHIFT with pending=4'b1010 -> next cycle cs_n=1, sclk=0, pending=0, busy=0, and no done pulse.
REQ-036 After ch3 was last served, strobe ch0 and ch3 together -> ch0 is served first (round-robin wrap).

Source files
------------

// File: rtl/dac_update_scheduler_pkg.sv
// rtl/dac_update_scheduler_pkg.sv - shared states, channel indices and frame layout for the DAC update scheduler
package dac_update_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] DDS_GAIN = 2'd0;
    localparam logic [1:0] CW_GAIN  = 2'd1;
    localparam logic [1:0] DDS_ILIM = 2'd2;
    localparam logic [1:0] CW_ILIM  = 2'd3;

    localparam int NUM_CH  = 4;
    localparam int FRAME_W = 24;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]  cmd,
                                                       input logic [1:0]  ch,
                                                       input logic [15:0] value);
        return {cmd, 2'b00, ch, value};
    endfunction

endpackage

// File: rtl/dac_update_scheduler_spi_tx.sv
// rtl/dac_update_scheduler_spi_tx.sv - dac_spi_frame_tx: mode-0 SPI serializer for one 24-bit DAC frame
module dac_spi_frame_tx
    import dac_update_scheduler_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               sclk_o,
    output logic               cs_n_o,
    output logic               mosi_o
);

    localparam logic [8:0] DIV_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] PER_LAST = 9'(2 * CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'(FRAME_W - 1);

    tx_state_e          state_q, state_d;
    logic [8:0]         cnt_q, cnt_d;
    logic [4:0]         bit_q, bit_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic               sclk_q, sclk_d;
    logic               cs_n_q, cs_n_d;
    logic               mosi_q, mosi_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
        end
    end

    // Pin values are computed one cycle ahead so every dac pin leaves a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    shreg_d = data_i;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = data_i[FRAME_W-1];
                end
            end
            SETUP: begin
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == DIV_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b1;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == DIV_LAST) begin
                    sclk_d  = 1'b0;
                    shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                    mosi_d  = shreg_q[FRAME_W-2];
                end else if (cnt_q == PER_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        bit_d  = bit_q + 5'd1;
                        sclk_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == DIV_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                end
            end
            GAP: begin
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == DIV_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == GAP) && (cnt_q == DIV_LAST);
    assign sclk_o = sclk_q;
    assign cs_n_o = cs_n_q;
    assign mosi_o = mosi_q;

endmodule

// File: rtl/dac_update_scheduler.sv
// rtl/dac_update_scheduler.sv - round-robin arbitration of four DAC channel update requests onto one SPI link
module dac_update_scheduler
    import dac_update_scheduler_pkg::*;
#(
    parameter int         CLK_DIV   = 4,
    parameter logic [3:0] CMD_WRITE = 4'h3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dds_gain_update,
    input  logic              cw_gain_update,
    input  logic              dds_current_limit_update,
    input  logic              cw_current_limit_update,
    input  logic [15:0]       dds_gain,
    input  logic [15:0]       cw_gain,
    input  logic [15:0]       dds_current_limit,
    input  logic [15:0]       cw_current_limit,
    output logic              dac_sclk,
    output logic              dac_cs_n,
    output logic              dac_mosi,
    output logic              busy,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] done
);

    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        ch_q, ch_d;
    logic [NUM_CH-1:0] strobe_vec;
    logic [NUM_CH-1:0] grant_mask;
    logic              grant_valid;
    logic [1:0]        grant_ch;
    logic [1:0]        cand;
    logic [15:0]       grant_value;
    logic              start;
    logic              tx_busy;
    logic              tx_done;

    always_comb begin
        strobe_vec           = '0;
        strobe_vec[DDS_GAIN] = dds_gain_update;
        strobe_vec[CW_GAIN]  = cw_gain_update;
        strobe_vec[DDS_ILIM] = dds_current_limit_update;
        strobe_vec[CW_ILIM]  = cw_current_limit_update;
    end

    // Search starts just after the last served channel; i == NUM_CH wraps to last_q itself.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = last_q;
        cand        = last_q;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = last_q + 2'(i);
            if (!grant_valid && pending_q[cand]) begin
                grant_valid = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    always_comb begin
        case (grant_ch)
            DDS_GAIN: grant_value = dds_gain;
            CW_GAIN:  grant_value = cw_gain;
            DDS_ILIM: grant_value = dds_current_limit;
            CW_ILIM:  grant_value = cw_current_limit;
            default:  grant_value = dds_gain;
        endcase
    end

    assign start      = grant_valid && !tx_busy;
    assign grant_mask = start ? (NUM_CH'(1) << grant_ch) : '0;

    // A strobe in the grant cycle re-arms the bit, so the newer value gets its own frame.
    always_comb begin
        pending_d = (pending_q & ~grant_mask) | strobe_vec;
        last_d    = start ? grant_ch : last_q;
        ch_d      = start ? grant_ch : ch_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            last_q    <= 2'd3;
            ch_q      <= 2'd0;
        end else begin
            pending_q <= pending_d;
            last_q    <= last_d;
            ch_q      <= ch_d;
        end
    end

    dac_spi_frame_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .start_i(start),
        .data_i (build_frame(CMD_WRITE, grant_ch, grant_value)),
        .busy_o (tx_busy),
        .done_o (tx_done),
        .sclk_o (dac_sclk),
        .cs_n_o (dac_cs_n),
        .mosi_o (dac_mosi)
    );

    assign busy    = tx_busy;
    assign pending = pending_q;
    assign done    = tx_done ? (NUM_CH'(1) << ch_q) : '0;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// tb/tb_dac_update_scheduler.sv - self-checking bench for dac_update_scheduler
module tb_dac_update_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        dds_gain_update, cw_gain_update, dds_current_limit_update, cw_current_limit_update;
    logic [15:0] dds_gain, cw_gain, dds_current_limit, cw_current_limit;
    logic        dac_sclk, dac_cs_n, dac_mosi, busy;
    logic [3:0]  pending, done;

    dac_update_scheduler #(.CLK_DIV(4), .CMD_WRITE(4'h3)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .dds_gain_update         (dds_gain_update),
        .cw_gain_update          (cw_gain_update),
        .dds_current_limit_update(dds_current_limit_update),
        .cw_current_limit_update (cw_current_limit_update),
        .dds_gain                (dds_gain),
        .cw_gain                 (cw_gain),
        .dds_current_limit       (dds_current_limit),
        .cw_current_limit        (cw_current_limit),
        .dac_sclk                (dac_sclk),
        .dac_cs_n                (dac_cs_n),
        .dac_mosi                (dac_mosi),
        .busy                    (busy),
        .pending                 (pending),
        .done                    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] value;
        logic [23:0] word;
        logic [3:0]  done_exp;
    } vec_t;

    typedef struct {
        logic [23:0] word;
        logic [3:0]  done_exp;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[4];
    int   n_checks = 0;
    int   n_fail = 0;
    logic aborting = 1'b0;
    logic done_armed = 1'b0;
    logic [3:0] exp_done = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic push_exp(input logic [23:0] word, input logic [3:0] d);
        exp_t e;
        e.word     = word;
        e.done_exp = d;
        sb.push_back(e);
    endtask

    task automatic set_strobes(input logic [3:0] s);
        dds_gain_update          = s[0];
        cw_gain_update           = s[1];
        dds_current_limit_update = s[2];
        cw_current_limit_update  = s[3];
    endtask

    task automatic set_value(input logic [1:0] ch, input logic [15:0] v);
        case (ch)
            2'd0:    dds_gain = v;
            2'd1:    cw_gain = v;
            2'd2:    dds_current_limit = v;
            default: cw_current_limit = v;
        endcase
    endtask

    task automatic strobe(input logic [3:0] s);
        set_strobes(s);
        @(negedge clk);
        set_strobes(4'b0000);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy !== 1'b0 || pending !== 4'b0000 || dac_cs_n !== 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (busy !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", 32'(n < budget), 1);
    endtask

    // Frame monitor: decodes SPI on sclk rising edges and checks against the scoreboard.
    logic        prev_cs_n = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0, have_frame = 1'b0;
    logic [23:0] mon_word = '0;
    int          mon_bits = 0, gap_cnt = 0, busy_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (dac_cs_n === 1'b0 && prev_cs_n === 1'b1) begin
            if (have_frame) chk("gap_min", 32'(gap_cnt >= 4), 1);
            have_frame = 1'b1;
            mon_bits   = 0;
            mon_word   = '0;
        end
        if (dac_cs_n === 1'b1) gap_cnt++;
        else gap_cnt = 0;
        if (dac_cs_n === 1'b0 && dac_sclk === 1'b1 && prev_sclk === 1'b0) begin
            mon_word = {mon_word[22:0], dac_mosi};
            mon_bits++;
        end
        if (dac_cs_n === 1'b1 && prev_cs_n === 1'b0 && !aborting) begin
            chk("frame_bits", mon_bits, 24);
            chk("mosi_idle", 32'(dac_mosi), 0);
            chk("done_missing", 32'(done_armed), 0);
            chk("frame_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("frame_word", 32'(mon_word), 32'(e.word));
                exp_done   = e.done_exp;
                done_armed = 1'b1;
            end
        end
        if (done !== 4'b0000) begin
            if (!done_armed) begin
                chk("done_unexpected", 32'(done), 0);
            end else begin
                chk("done_bits", 32'(done), 32'(exp_done));
                done_armed = 1'b0;
            end
        end
        if (busy === 1'b1 && prev_busy !== 1'b1) busy_cnt = 0;
        if (busy === 1'b1) busy_cnt++;
        if (busy === 1'b0 && prev_busy === 1'b1 && !aborting) chk("frame_len", 1 + busy_cnt, 205);
        prev_cs_n = dac_cs_n;
        prev_sclk = dac_sclk;
        prev_busy = busy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rises;
        logic psclk;
        rst = 1'b1;
        set_strobes(4'b0000);
        dds_gain = '0; cw_gain = '0; dds_current_limit = '0; cw_current_limit = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(dac_cs_n), 1);
        chk("rst_sclk", 32'(dac_sclk), 0);
        chk("rst_mosi", 32'(dac_mosi), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single-channel frames
        vecs[0] = '{ch: 2'd0, value: 16'hA5C3, word: 24'h30A5C3, done_exp: 4'b0001};
        vecs[1] = '{ch: 2'd1, value: 16'h1234, word: 24'h311234, done_exp: 4'b0010};
        vecs[2] = '{ch: 2'd2, value: 16'hFFFF, word: 24'h32FFFF, done_exp: 4'b0100};
        vecs[3] = '{ch: 2'd3, value: 16'h0000, word: 24'h330000, done_exp: 4'b1000};
        for (int i = 0; i < 4; i++) begin
            set_value(vecs[i].ch, vecs[i].value);
            push_exp(vecs[i].word, vecs[i].done_exp);
            strobe(vecs[i].done_exp);
            chk("single_pending", 32'(pending), 32'(vecs[i].done_exp));
            chk("single_busy_pre", 32'(busy), 0);
            wait_idle(1000);
        end

        // All four at once, served in channel order
        dds_gain = 16'h0A0A; cw_gain = 16'h0B0B; dds_current_limit = 16'h0C0C; cw_current_limit = 16'h0D0D;
        push_exp(24'h300A0A, 4'b0001);
        push_exp(24'h310B0B, 4'b0010);
        push_exp(24'h320C0C, 4'b0100);
        push_exp(24'h330D0D, 4'b1000);
        strobe(4'b1111);
        chk("all_pending", 32'(pending), 32'hF);
        wait_idle(4000);
        chk("all_drained", 32'(pending), 0);

        // Wrap: ch3 was last, so ch0 goes before ch3
        push_exp(24'h300A0A, 4'b0001);
        push_exp(24'h330D0D, 4'b1000);
        strobe(4'b1001);
        wait_idle(2000);

        // Coalescing: three strobes mid-frame give one frame with the latest value
        cw_gain = 16'hBEEF;
        push_exp(24'h31BEEF, 4'b0010);
        push_exp(24'h310003, 4'b0010);
        strobe(4'b0010);
        wait_busy(10);
        repeat (20) @(negedge clk);
        for (int v = 1; v <= 3; v++) begin
            cw_gain = 16'(v);
            strobe(4'b0010);
            repeat (5) @(negedge clk);
        end
        chk("coalesce_pending", 32'(pending), 32'h2);
        chk("coalesce_busy", 32'(busy), 1);
        wait_idle(2000);

        // Strobe on the grant cycle re-arms the channel
        dds_current_limit = 16'h1111;
        push_exp(24'h321111, 4'b0100);
        push_exp(24'h322222, 4'b0100);
        set_strobes(4'b0100);
        @(negedge clk);
        chk("grant_cycle_busy", 32'(busy), 0);
        chk("grant_cycle_pending", 32'(pending), 32'h4);
        @(negedge clk);
        set_strobes(4'b0000);
        dds_current_limit = 16'h2222;
        chk("rearm_busy", 32'(busy), 1);
        chk("rearm_pending", 32'(pending), 32'h4);
        wait_idle(2000);

        // Reset at bit 10 of SHIFT with two channels pending
        dds_gain = 16'h5555;
        strobe(4'b0001);
        wait_busy(10);
        strobe(4'b1010);
        chk("abort_pending", 32'(pending), 32'hA);
        rises = 0;
        psclk = dac_sclk;
        for (int n = 0; n < 400 && rises < 11; n++) begin
            @(negedge clk);
            if (dac_sclk === 1'b1 && psclk === 1'b0) rises++;
            psclk = dac_sclk;
        end
        chk("abort_reach_bit10", rises, 11);
        aborting = 1'b1;
        rst = 1'b1;
        set_strobes(4'b0001);
        @(negedge clk);
        rst = 1'b0;
        set_strobes(4'b0000);
        chk("abort_cs_n", 32'(dac_cs_n), 1);
        chk("abort_sclk", 32'(dac_sclk), 0);
        chk("abort_mosi", 32'(dac_mosi), 0);
        chk("abort_pending_clr", 32'(pending), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        repeat (20) @(negedge clk);
        chk("abort_quiet_busy", 32'(busy), 0);
        chk("abort_quiet_pending", 32'(pending), 0);
        aborting = 1'b0;

        // Recovery frame after the aborted one
        cw_current_limit = 16'h7E57;
        push_exp(24'h337E57, 4'b1000);
        strobe(4'b1000);
        wait_idle(1000);

        chk("sb_empty", sb.size(), 0);
        chk("done_left_armed", 32'(done_armed), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
